// File: rtl/shift_r_arbiter.sv
// rtl/shift_r_arbiter.sv - round-robin arbiter sharing one right-shift datapath
//
// Purpose: NREQ requesters share a single arithmetic/logical right shifter.
//   A round-robin pointer picks the next valid requester whenever the result
//   slot can take a new entry. Each result is tagged with the requester index.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   req_vld  in   [NREQ]          request valid per requester
//   req_rdy  out  [NREQ]          one-hot grant (or zero)
//   req_a    in   [NREQ*width_a]  operands, requester i at [i*width_a +: width_a]
//   req_s    in   [NREQ*width_s]  shift amounts, requester i at [i*width_s +: width_s]
//   rsp_vld  out  result valid
//   rsp_rdy  in   downstream accepts result
//   rsp_z    out  [width_z]       shifted result
//   rsp_id   out  [clog2(NREQ)]   requester index of rsp_z
//
// Build option: SHIFT_R_ARB_PIPE2_EN adds an operand stage ahead of the
//   result stage (accept-to-response latency 2 instead of 1).

module shift_r_arbiter #(
  parameter int NREQ    = 4,
  parameter int width_a = 16,
  parameter int width_s = 4,
  parameter int width_z = 16,
  parameter bit signd_a = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_vld,
  output logic [NREQ-1:0]            req_rdy,
  input  logic [NREQ*width_a-1:0]    req_a,
  input  logic [NREQ*width_s-1:0]    req_s,
  output logic                       rsp_vld,
  input  logic                       rsp_rdy,
  output logic [width_z-1:0]         rsp_z,
  output logic [$clog2(NREQ)-1:0]    rsp_id
);

  localparam int IDW = $clog2(NREQ);
  // Logical mode needs one spare zero bit so the top operand bit is never
  // mistaken for a sign; the extension is also never narrower than the result.
  localparam int AW  = width_a + (signd_a ? 0 : 1);
  localparam int LW  = (AW > width_z) ? AW : width_z;

  // The extra top bit carries the fill value, so a signed >>> yields sign bits
  // (or zeros) for any shift amount, including amounts beyond LW.
  function automatic logic [width_z-1:0] shift_fn(input logic [width_a-1:0] a,
                                                  input logic [width_s-1:0] s);
    logic              fill;
    logic signed [LW:0] ext;
    fill = signd_a ? a[width_a-1] : 1'b0;
    ext  = {{(LW+1-width_a){fill}}, a};
    return width_z'(ext >>> s);
  endfunction

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               out_vld_q, out_vld_d;
  logic [width_z-1:0] out_z_q, out_z_d;
  logic [IDW-1:0]     out_id_q, out_id_d;

  logic               slot_free;
  logic               gnt_found;
  logic [IDW-1:0]     gnt_id;
  logic               accept;
  logic [width_a-1:0] sel_a;
  logic [width_s-1:0] sel_s;

`ifdef SHIFT_R_ARB_PIPE2_EN
  logic               s1_vld_q, s1_vld_d;
  logic [width_a-1:0] s1_a_q, s1_a_d;
  logic [width_s-1:0] s1_s_q, s1_s_d;
  logic [IDW-1:0]     s1_id_q, s1_id_d;
  logic               s1_adv;

  assign s1_adv    = s1_vld_q && (!out_vld_q || rsp_rdy);
  assign slot_free = !s1_vld_q || s1_adv;
`else
  assign slot_free = !out_vld_q || rsp_rdy;
`endif

  // Rotating priority search starting at rr_ptr; depends only on valids.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_vld[(int'(rr_ptr_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign accept = slot_free && gnt_found && !rst;

  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[gnt_id] = 1'b1;
  end

  assign sel_a = req_a[int'(gnt_id)*width_a +: width_a];
  assign sel_s = req_s[int'(gnt_id)*width_s +: width_s];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    out_vld_d = out_vld_q;
    out_z_d   = out_z_q;
    out_id_d  = out_id_q;
    if (accept) begin
      rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : IDW'(gnt_id + 1'b1);
    end
`ifdef SHIFT_R_ARB_PIPE2_EN
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_s_d   = s1_s_q;
    s1_id_d  = s1_id_q;
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_a_d   = sel_a;
      s1_s_d   = sel_s;
      s1_id_d  = gnt_id;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end
    if (s1_adv) begin
      out_vld_d = 1'b1;
      out_z_d   = shift_fn(s1_a_q, s1_s_q);
      out_id_d  = s1_id_q;
    end else if (rsp_rdy) begin
      out_vld_d = 1'b0;
    end
`else
    // A new accept and a drain can share an edge; the new result simply replaces.
    if (accept) begin
      out_vld_d = 1'b1;
      out_z_d   = shift_fn(sel_a, sel_s);
      out_id_d  = gnt_id;
    end else if (rsp_rdy) begin
      out_vld_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      out_vld_q <= 1'b0;
      out_z_q   <= '0;
      out_id_q  <= '0;
`ifdef SHIFT_R_ARB_PIPE2_EN
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_s_q    <= '0;
      s1_id_q   <= '0;
`endif
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      out_vld_q <= out_vld_d;
      out_z_q   <= out_z_d;
      out_id_q  <= out_id_d;
`ifdef SHIFT_R_ARB_PIPE2_EN
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_s_q    <= s1_s_d;
      s1_id_q   <= s1_id_d;
`endif
    end
  end

  assign rsp_vld = out_vld_q;
  assign rsp_z   = out_z_q;
  assign rsp_id  = out_id_q;

endmodule

// File: tb/tb_shift_r_arbiter.sv
// tb/tb_shift_r_arbiter.sv - scoreboard bench for shift_r_arbiter
module tb_shift_r_arbiter;

`ifdef SHIFT_R_ARB_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [3:0]  req_rdy;
  logic [63:0] req_a;
  logic [15:0] req_s;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [15:0] rsp_z;
  logic [1:0]  rsp_id;

  logic [3:0]  log_req_rdy;
  logic        log_rsp_vld;
  logic [15:0] log_rsp_z;
  logic [1:0]  log_rsp_id;

  always #5 clk = ~clk;

  shift_r_arbiter #(.NREQ(4), .width_a(16), .width_s(4), .width_z(16), .signd_a(1'b1)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_s(req_s),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_z(rsp_z), .rsp_id(rsp_id));

  shift_r_arbiter #(.NREQ(4), .width_a(16), .width_s(4), .width_z(16), .signd_a(1'b0)) u_log (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(log_req_rdy), .req_a(req_a), .req_s(req_s),
    .rsp_vld(log_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_z(log_rsp_z), .rsp_id(log_rsp_id));

  typedef struct {
    logic [15:0] z;
    logic [1:0]  id;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] exp_z [4];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          lat_on = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [3:0] s, input logic [15:0] z);
    req_a[i*16 +: 16] = a;
    req_s[i*4 +: 4]   = s;
    exp_z[i]          = z;
  endtask

  // One clock: drive inputs, check the grant at negedge, push the expected result.
  task automatic do_cycle(input logic [3:0] vld, input logic rrdy, input logic [3:0] exp_rdy, input string nm);
    exp_t e;
    req_vld = vld;
    rsp_rdy = rrdy;
    @(negedge clk);
    chk(nm, req_rdy, exp_rdy);
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        e.z   = exp_z[i];
        e.id  = 2'(i);
        e.due = lat_on ? cyc + LAT : -1;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [15:0] z, input logic [1:0] id);
    chk({nm, "_vld"}, rsp_vld, v);
    chk({nm, "_z"}, rsp_z, z);
    chk({nm, "_id"}, rsp_id, id);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d z %0h, expected no response (cycle %0d)", rsp_id, rsp_z, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_z", rsp_z, mon_e.z);
        chk("rsp_id", rsp_id, mon_e.id);
        if (mon_e.due >= 0) chk("rsp_latency", cyc, mon_e.due);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    req_vld = 4'b1111;
    rsp_rdy = 1'b0;
    req_a   = '0;
    req_s   = '0;
    set_req(0, 16'h1234, 4'd0,  16'h1234);
    set_req(1, 16'h8000, 4'd15, 16'hFFFF);
    set_req(2, 16'h7FFF, 4'd15, 16'h0000);
    set_req(3, 16'hF0F0, 4'd4,  16'hFF0F);

    // Reset with every requester valid
    do_cycle(4'b1111, 1'b0, 4'b0000, "rst_req_rdy0");
    chk_out("rst_out0", 1'b0, 16'h0000, 2'd0);
    do_cycle(4'b1111, 1'b0, 4'b0000, "rst_req_rdy1");
    chk_out("rst_out1", 1'b0, 16'h0000, 2'd0);
    rst = 1'b0;

    // Round robin with all held valid, each requester drops after its last transfer
    do_cycle(4'b1111, 1'b1, 4'b0001, "rr_g0");
    do_cycle(4'b1111, 1'b1, 4'b0010, "rr_g1");
    do_cycle(4'b1111, 1'b1, 4'b0100, "rr_g2");
    do_cycle(4'b1111, 1'b1, 4'b1000, "rr_g3");
    do_cycle(4'b1111, 1'b1, 4'b0001, "rr_g0b");
    do_cycle(4'b1110, 1'b1, 4'b0010, "rr_g1b");
    do_cycle(4'b1100, 1'b1, 4'b0100, "rr_g2b");
    do_cycle(4'b1000, 1'b1, 4'b1000, "rr_g3b");

    // Pointer wrapped 3->0: req 1 wins over req 3
    set_req(1, 16'h0F00, 4'd8, 16'h000F);
    set_req(3, 16'hFF00, 4'd8, 16'hFFFF);
    do_cycle(4'b1010, 1'b1, 4'b0010, "rr_wrap");
    do_cycle(4'b1000, 1'b1, 4'b1000, "rr_after_wrap");
    repeat (3) do_cycle(4'b0000, 1'b1, 4'b0000, "idle");

    // Single requester 2, arithmetic vs logical fill
    set_req(2, 16'h8000, 4'd4, 16'hF800);
    do_cycle(4'b0100, 1'b1, 4'b0100, "single_req2");
    if (LAT == 2) do_cycle(4'b0000, 1'b1, 4'b0000, "single_wait");
    chk("logical_vld", log_rsp_vld, 1'b1);
    chk("logical_z", log_rsp_z, 16'h0800);
    chk("logical_id", log_rsp_id, 2'd2);
    repeat (2) do_cycle(4'b0000, 1'b1, 4'b0000, "idle");

    // Backpressure for 5 cycles, then drain and accept on the same edge
    lat_on = 1'b0;
    set_req(0, 16'h00F0, 4'd4, 16'h000F);
    set_req(1, 16'h4000, 4'd1, 16'h2000);
    set_req(2, 16'hC000, 4'd2, 16'hF000);
    do_cycle(4'b0001, 1'b0, 4'b0001, "bp_grant0");
    for (int i = 0; i < 5; i++) begin
      do_cycle((LAT == 2 && i > 0) ? 4'b0000 : 4'b0010, 1'b0,
               (LAT == 2 && i == 0) ? 4'b0010 : 4'b0000, "bp_hold_rdy");
      chk_out("bp_hold", 1'b1, 16'h000F, 2'd0);
    end
    do_cycle((LAT == 2) ? 4'b0100 : 4'b0010, 1'b1, (LAT == 2) ? 4'b0100 : 4'b0010, "bp_release");
    chk_out("bp_after", 1'b1, 16'h2000, 2'd1);
    repeat (3) do_cycle(4'b0000, 1'b1, 4'b0000, "idle");
    lat_on = 1'b1;

    // Reset while a result is pending under backpressure
    set_req(3, 16'h0001, 4'd0, 16'h0001);
    do_cycle(4'b1000, 1'b0, 4'b1000, "rst6_grant");
    do_cycle(4'b0000, 1'b0, 4'b0000, "rst6_wait");
    chk("rst6_pending", rsp_vld, 1'b1);
    rst = 1'b1;
    sbq.delete();
    do_cycle(4'b1111, 1'b0, 4'b0000, "rst6_req_rdy");
    chk_out("rst6_out", 1'b0, 16'h0000, 2'd0);
    rst = 1'b0;
    do_cycle(4'b1111, 1'b1, 4'b0001, "post_rst_g0");
    do_cycle(4'b1110, 1'b1, 4'b0010, "post_rst_g1");
    do_cycle(4'b1100, 1'b1, 4'b0100, "post_rst_g2");
    do_cycle(4'b1000, 1'b1, 4'b1000, "post_rst_g3");
    repeat (4) do_cycle(4'b0000, 1'b1, 4'b0000, "idle");

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
